// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// fault causes and the default bus timeout.
package load_store_unit_pkg;

   localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_TIMEOUT  = 2'b10,
      CAUSE_ILLEGAL  = 2'b11
   } fault_cause_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering for stores, lane extraction and sign/zero
// extension for loads, plus illegal-funct3 and misalignment detection.
module load_store_unit_lane_align
   import load_store_unit_pkg::*;
(
   input  logic        write_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o,
   output logic        illegal_o
);

   logic [7:0]  lane_bytes [4];
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_bytes[gi] = rdata_i[8*gi +: 8];
   end

   assign lane_byte = lane_bytes[offset_i];
   assign lane_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // Stores only have B/H/W; loads additionally allow BU/HU.
   assign illegal_o = write_i ? (funct3_i[2] || (funct3_i[1:0] == 2'b11))
                              : ((funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110));

   always_comb begin
      be_o         = 4'b0000;
      wdata_o      = wdata_i;
      misaligned_o = 1'b0;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o         = offset_i[1] ? 4'b1100 : 4'b0011;
            wdata_o      = {2{wdata_i[15:0]}};
            misaligned_o = offset_i[0];
         end
         2'b10: begin
            be_o         = 4'b1111;
            misaligned_o = (offset_i != 2'b00);
         end
         default: ;
      endcase
   end

   always_comb begin
      rdata_o = 32'h0;
      case (funct3_i)
         F3_B:    rdata_o = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   rdata_o = {24'h0, lane_byte};
         F3_H:    rdata_o = {{16{lane_half[15]}}, lane_half};
         F3_HU:   rdata_o = {16'h0, lane_half};
         F3_W:    rdata_o = rdata_i;
         default: rdata_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: IDLE/WAIT/RESP FSM, bus timeout counter
// and registered response/bus outputs; stalls the core until each access completes.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   input  logic              req_write_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              stall_o,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              fault_o,
   output logic [1:0]        fault_cause_o,
   load_store_unit_if.master mem
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   lsu_state_e          state_q, state_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          offset_q, offset_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                fault_q, fault_d;
   fault_cause_e        cause_q, cause_d;

   logic [2:0]          lane_funct3;
   logic [1:0]          lane_offset;
   logic [3:0]          lane_be;
   logic [31:0]         lane_wdata;
   logic [31:0]         lane_rdata;
   logic                lane_misaligned;
   logic                lane_illegal;
   logic                tmo_expired;

   // In IDLE the lane logic checks the live request; in WAIT it extracts
   // load data using the attributes captured when the access was issued.
   assign lane_funct3 = (state_q == ST_IDLE) ? req_funct3_i    : funct3_q;
   assign lane_offset = (state_q == ST_IDLE) ? req_addr_i[1:0] : offset_q;

   load_store_unit_lane_align u_lane_align (
      .write_i      (req_write_i),
      .funct3_i     (lane_funct3),
      .offset_i     (lane_offset),
      .wdata_i      (req_wdata_i),
      .rdata_i      (mem.mem_rdata),
      .be_o         (lane_be),
      .wdata_o      (lane_wdata),
      .rdata_o      (lane_rdata),
      .misaligned_o (lane_misaligned),
      .illegal_o    (lane_illegal)
   );

   assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tmo_q        <= '0;
         funct3_q     <= '0;
         offset_q     <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         fault_q      <= 1'b0;
         cause_q      <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         funct3_q     <= funct3_d;
         offset_q     <= offset_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         fault_q      <= fault_d;
         cause_q      <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid_i) state_d = (lane_illegal || lane_misaligned) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (mem.mem_ack || tmo_expired) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Response fields are only non-zero during the single RESP cycle.
   always_comb begin
      tmo_d        = tmo_q;
      funct3_d     = funct3_q;
      offset_d     = offset_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      fault_d      = 1'b0;
      cause_d      = CAUSE_NONE;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (lane_illegal) begin
                  resp_valid_d = 1'b1;
                  fault_d      = 1'b1;
                  cause_d      = CAUSE_ILLEGAL;
               end else if (lane_misaligned) begin
                  resp_valid_d = 1'b1;
                  fault_d      = 1'b1;
                  cause_d      = CAUSE_MISALIGN;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_write_i;
                  mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = lane_wdata;
                  mem_be_d    = lane_be;
                  funct3_d    = req_funct3_i;
                  offset_d    = req_addr_i[1:0];
                  tmo_d       = '0;
               end
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (mem.mem_ack) begin
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = mem_we_q ? '0 : lane_rdata;
            end else if (tmo_expired) begin
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               fault_d      = 1'b1;
               cause_d      = CAUSE_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   assign stall_o       = req_valid_i && (state_q != ST_RESP);
   assign resp_valid_o  = resp_valid_q;
   assign resp_rdata_o  = resp_rdata_q;
   assign fault_o       = fault_q;
   assign fault_cause_o = cause_q;

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus
// hand-written reset, request-drop, stray-ack and back-to-back sequences.
module tb_load_store_unit;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack;        // WAIT cycle carrying mem_ack; 0 means never
      logic [31:0] rdata;
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] exp_rdata;
      logic [3:0]  be;
      logic [31:0] exp_wdata;
      int          lat;        // cycles from request cycle to resp_valid
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        fault;
   logic [1:0]  fault_cause;

   int checks = 0;
   int errors = 0;
   vec_t vecs [17];

   load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid),
      .req_write_i   (req_write),
      .req_funct3_i  (req_funct3),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .stall_o       (stall),
      .resp_valid_o  (resp_valid),
      .resp_rdata_o  (resp_rdata),
      .fault_o       (fault),
      .fault_cause_o (fault_cause),
      .mem           (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int   stall_n = 0;
      int   widx = 0;
      int   lat = -1;
      bit   bus_bad = 0;
      bit   req_seen = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = v.wr;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (stall) stall_n++;
         if (bus.mem_req) begin
            req_seen = 1;
            widx++;
            if (bus.mem_we !== v.wr || bus.mem_addr !== {v.addr[31:2], 2'b00} ||
                bus.mem_be !== v.be || (v.wr && bus.mem_wdata !== v.exp_wdata))
               bus_bad = 1;
            if (widx == v.ack) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = v.rdata;
            end else begin
               bus.mem_ack   = 1'b0;
               bus.mem_rdata = 32'h5A5A_5A5A;
            end
         end else begin
            bus.mem_ack = 1'b0;
         end
         if (resp_valid) begin
            lat = i;
            chk({nm, "_fault"}, fault, v.fault);
            chk({nm, "_cause"}, fault_cause, v.cause);
            chk({nm, "_rdata"}, resp_rdata, v.exp_rdata);
            chk({nm, "_req_in_resp"}, bus.mem_req, 1'b0);
            req_valid = 1'b0;
         end
      end
      bus.mem_ack = 1'b0;
      chk({nm, "_latency"}, lat, v.lat);
      chk({nm, "_stall_cycles"}, stall_n, v.lat);
      if (v.fault && v.cause != 2'b10) begin
         chk({nm, "_no_mem_req"}, req_seen, 1'b0);
      end else begin
         chk({nm, "_mem_req_seen"}, req_seen, 1'b1);
         chk({nm, "_bus_fields"}, bus_bad, 1'b0);
      end
      $display("txn %s: wr=%0d f3=%03b addr=0x%08h lat=%0d fault=%0d cause=%02b rdata=0x%08h",
               nm, v.wr, v.f3, v.addr, lat, fault, fault_cause, resp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int   lat;
      bit   rv_seen;

      //          wr    f3      addr          wdata          ack rdata          flt  cause  exp_rdata      be      exp_wdata      lat
      vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'hDEAD_BEEF, 4'hF, 32'h0,         4};
      vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,         1, 32'h8012_3456, 1'b0, 2'b00, 32'hFFFF_FF80, 4'h8, 32'h0,         2};
      vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,         2, 32'h8012_3456, 1'b0, 2'b00, 32'h0000_0080, 4'h8, 32'h0,         3};
      vecs[3]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,         1, 32'h8012_3456, 1'b0, 2'b00, 32'h0000_8012, 4'hC, 32'h0,         2};
      vecs[4]  = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,         1, 32'h1234_8001, 1'b0, 2'b00, 32'hFFFF_8001, 4'h3, 32'h0,         2};
      vecs[5]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,         1, 32'h1234_7F56, 1'b0, 2'b00, 32'h0000_007F, 4'h2, 32'h0,         2};
      vecs[6]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1, 32'hFFFF_FFFF, 1'b0, 2'b00, 32'h0,         4'hC, 32'hABCD_ABCD, 2};
      vecs[7]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 2, 32'h0,         1'b0, 2'b00, 32'h0,         4'h2, 32'hA5A5_A5A5, 3};
      vecs[8]  = '{1'b1, 3'b010, 32'h0000_0104, 32'h1122_3344, 1, 32'h0,         1'b0, 2'b00, 32'h0,         4'hF, 32'h1122_3344, 2};
      vecs[9]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,         0, 32'h0,         1'b1, 2'b01, 32'h0,         4'h0, 32'h0,         1};
      vecs[10] = '{1'b1, 3'b011, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, 2'b11, 32'h0,         4'h0, 32'h0,         1};
      vecs[11] = '{1'b1, 3'b100, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, 2'b11, 32'h0,         4'h0, 32'h0,         1};
      vecs[12] = '{1'b0, 3'b011, 32'h0000_0101, 32'h0,         0, 32'h0,         1'b1, 2'b11, 32'h0,         4'h0, 32'h0,         1};
      vecs[13] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         0, 32'h0,         1'b1, 2'b01, 32'h0,         4'h0, 32'h0,         1};
      vecs[14] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, 2'b11, 32'h0,         4'h0, 32'h0,         1};
      vecs[15] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         0, 32'h0,         1'b1, 2'b10, 32'h0,         4'hF, 32'h0,         9};
      vecs[16] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         8, 32'hCAFE_F00D, 1'b0, 2'b00, 32'hCAFE_F00D, 4'hF, 32'h0,         9};

      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_cause", fault_cause, 2'b00);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_mem_be", bus.mem_be, 4'h0);
      chk("rst_stall", stall, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Response is a single-cycle pulse
      @(negedge clk);
      #1;
      chk("resp_pulse_width", resp_valid, 1'b0);

      // Stray ack while idle is ignored
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1111_2222;
      @(negedge clk);
      #1;
      bus.mem_ack = 1'b0;
      chk("idle_ack_resp", resp_valid, 1'b0);
      chk("idle_ack_req", bus.mem_req, 1'b0);
      $display("txn idle_ack: resp_valid=%0d mem_req=%0d", resp_valid, bus.mem_req);

      // req_valid dropped mid-WAIT: the store still completes
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0108;
      req_wdata  = 32'h5566_7788;
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (i == 1) req_valid = 1'b0;
         bus.mem_ack = (i == 3);
         if (resp_valid) lat = i;
      end
      bus.mem_ack = 1'b0;
      chk("drop_latency", lat, 4);
      chk("drop_fault", fault, 1'b0);
      chk("drop_rdata", resp_rdata, 32'h0);
      $display("txn drop_req: lat=%0d fault=%0d", lat, fault);

      // Asynchronous reset in the middle of WAIT
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0300;
      @(negedge clk);
      #1;
      chk("rstwait_req_before", bus.mem_req, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstwait_req_async", bus.mem_req, 1'b0);
      chk("rstwait_resp_async", resp_valid, 1'b0);
      req_valid = 1'b0;
      rv_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid) rv_seen = 1;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         #1;
         if (resp_valid || bus.mem_req) rv_seen = 1;
      end
      chk("rstwait_no_resp", rv_seen, 1'b0);
      $display("txn reset_mid_wait: spurious_activity=%0d", rv_seen);
      run_vec(vecs[0], "post_reset_lw");

      // Back-to-back: fault then load immediately after the response
      run_vec(vecs[9], "b2b_fault");
      run_vec(vecs[1], "b2b_lb");

      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

endmodule
